op_sequencer: RTL and testbench

- Top-level command controller for the key/value cache memory block.
- Accepts one host request at a time over a valid/ready handshake and decodes the opcode (GET/PUT/DEL/NOP).
- Sequences the matching sub-FSM (get_fsm, put_fsm, del_fsm) through its en/enter/cmd protocol, then returns a status (plus GET data) over a valid/ready response channel.
- Guards every operation with a watchdog timeout.

---
 rtl/ctrl_types_pkg.sv | 41 ++++
 rtl/op_sequencer_if.sv | 27 ++
 rtl/op_timer.sv | 31 +++
 rtl/op_sequencer.sv | 157 +++++++++++++++
 tb/tb_op_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_types_pkg.sv
// Shared control types for the key/value cache controller: sub-FSM command
// bundle, host opcodes, response status codes and sequencer states.
package ctrl_types_pkg;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_GET = 2'd1,
        OP_PUT = 2'd2,
        OP_DEL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_NOT_FOUND = 2'd1,
        STATUS_FULL      = 2'd2,
        STATUS_TIMEOUT   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GET  = 3'd1,
        ST_PUT  = 3'd2,
        ST_DEL  = 3'd3,
        ST_RESP = 3'd4
    } seq_state_e;

    // Error outranks done; a failed PUT means the table is full, otherwise the key is missing.
    function automatic status_e cmd_status(input logic is_put, input sub_cmd_t cmd);
        if (cmd.error) begin
            return is_put ? STATUS_FULL : STATUS_NOT_FOUND;
        end else begin
            return STATUS_OK;
        end
    endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Host request/response channel of the op sequencer (two valid/ready handshakes).
interface op_sequencer_if #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 32
);
    import ctrl_types_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    op_e                    req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    status_e                resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_value
    );

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
        output req_ready, resp_valid, resp_status, resp_value
    );
endinterface

// File: rtl/op_timer.sv
// Watchdog counter for one operation: cleared outside op states, counts op cycles,
// flags expiry once the count reaches TIMEOUT_CYCLES-1.
module op_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Saturating cycle counter so a stalled abort cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);
endmodule

// File: rtl/op_sequencer.sv
// Command controller for the key/value cache: accepts one host request, runs the
// matching get/put/del sub-FSM under a watchdog, and returns a status response.
module op_sequencer
    import ctrl_types_pkg::*;
#(
    parameter int KEY_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    op_sequencer_if.slave          host,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   get_en,
    output logic                   put_en,
    output logic                   del_en,
    output logic                   get_enter,
    output logic                   put_enter,
    output logic                   del_enter,
    input  sub_cmd_t               get_cmd,
    input  sub_cmd_t               put_cmd,
    input  sub_cmd_t               del_cmd,
    input  logic [VALUE_WIDTH-1:0] get_value_in
);
    seq_state_e             state_r;
    logic                   resp_valid_r;
    status_e                resp_status_r;
    logic [VALUE_WIDTH-1:0] resp_value_r;
    sub_cmd_t               cur_cmd_s;
    logic                   entry_s;
    logic                   in_op_s;
    logic                   expired_s;

    // Select the command of whichever sub-FSM is currently active.
    always_comb begin
        cur_cmd_s = '0;
        case (state_r)
            ST_GET:  cur_cmd_s = get_cmd;
            ST_PUT:  cur_cmd_s = put_cmd;
            ST_DEL:  cur_cmd_s = del_cmd;
            default: cur_cmd_s = '0;
        endcase
    end

    assign entry_s = get_enter | put_enter | del_enter;
    assign in_op_s = (state_r == ST_GET) || (state_r == ST_PUT) || (state_r == ST_DEL);

    op_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_op_s),
        .enable  (in_op_s),
        .expired (expired_s)
    );

    // Sequencer FSM with all sub-FSM controls and response fields registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            key_out       <= '0;
            value_out     <= '0;
            get_en        <= 1'b0;
            put_en        <= 1'b0;
            del_en        <= 1'b0;
            get_enter     <= 1'b0;
            put_enter     <= 1'b0;
            del_enter     <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_status_r <= STATUS_OK;
            resp_value_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        key_out      <= host.req_key;
                        value_out    <= host.req_value;
                        resp_value_r <= '0;
                        case (host.req_op)
                            OP_GET: begin
                                state_r   <= ST_GET;
                                get_en    <= 1'b1;
                                get_enter <= 1'b1;
                            end
                            OP_PUT: begin
                                state_r   <= ST_PUT;
                                put_en    <= 1'b1;
                                put_enter <= 1'b1;
                            end
                            OP_DEL: begin
                                state_r   <= ST_DEL;
                                del_en    <= 1'b1;
                                del_enter <= 1'b1;
                            end
                            default: begin
                                state_r       <= ST_RESP;
                                resp_valid_r  <= 1'b1;
                                resp_status_r <= STATUS_OK;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GET, ST_PUT, ST_DEL: begin
                    get_enter <= 1'b0;
                    put_enter <= 1'b0;
                    del_enter <= 1'b0;
                    // Completion is ignored in the entry cycle and beats a coincident timeout.
                    if (!entry_s && (cur_cmd_s.done || cur_cmd_s.error)) begin
                        state_r       <= ST_RESP;
                        get_en        <= 1'b0;
                        put_en        <= 1'b0;
                        del_en        <= 1'b0;
                        resp_valid_r  <= 1'b1;
                        resp_status_r <= cmd_status(state_r == ST_PUT, cur_cmd_s);
                        if ((state_r == ST_GET) && !cur_cmd_s.error) begin
                            resp_value_r <= get_value_in;
                        end else begin
                            resp_value_r <= '0;
                        end
                    end else if (expired_s) begin
                        state_r       <= ST_RESP;
                        get_en        <= 1'b0;
                        put_en        <= 1'b0;
                        del_en        <= 1'b0;
                        resp_valid_r  <= 1'b1;
                        resp_status_r <= STATUS_TIMEOUT;
                        resp_value_r  <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RESP: begin
                    if (host.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    get_en       <= 1'b0;
                    put_en       <= 1'b0;
                    del_en       <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign host.req_ready   = (state_r == ST_IDLE);
    assign host.resp_valid  = resp_valid_r;
    assign host.resp_status = resp_status_r;
    assign host.resp_value  = resp_value_r;
endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus randomized
// operations checked against a rule-level model of the expected response.
module tb_op_sequencer;
    import ctrl_types_pkg::*;

    localparam int KW = 16;
    localparam int VW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic [KW-1:0] key_out;
    logic [VW-1:0] value_out;
    logic          get_en, put_en, del_en;
    logic          get_enter, put_enter, del_enter;
    logic [1:0]    get_cmd, put_cmd, del_cmd;
    logic [VW-1:0] get_value_in;

    int errors;
    int checks;

    op_sequencer_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) hif ();

    op_sequencer #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (hif.slave),
        .key_out      (key_out),
        .value_out    (value_out),
        .get_en       (get_en),
        .put_en       (put_en),
        .del_en       (del_en),
        .get_enter    (get_enter),
        .put_enter    (put_enter),
        .del_enter    (del_enter),
        .get_cmd      (get_cmd),
        .put_cmd      (put_cmd),
        .del_cmd      (del_cmd),
        .get_value_in (get_value_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete host transaction; expectations come from the operation rules only.
    task automatic run_op(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                          input int cmd_cycle, input logic [1:0] cmd, input logic [VW-1:0] gv,
                          input int delay, input string name);
        int         exp_cycles;
        logic [1:0] exp_status;
        logic [VW-1:0] exp_value;
        logic [2:0] exp_en;
        int         n;
        logic [1:0] held_status;
        logic [VW-1:0] held_value;

        exp_en = (op == 2'd1) ? 3'b100 : (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b001 : 3'b000;
        if (op == 2'd0) begin
            exp_cycles = 0; exp_status = 2'd0; exp_value = '0;
        end else if ((cmd != 2'b00) && (cmd_cycle >= 2) && (cmd_cycle <= TO)) begin
            exp_cycles = cmd_cycle;
            if (cmd[0]) exp_status = (op == 2'd2) ? 2'd2 : 2'd1;
            else        exp_status = 2'd0;
            exp_value = ((op == 2'd1) && !cmd[0]) ? gv : '0;
        end else begin
            exp_cycles = TO; exp_status = 2'd3; exp_value = '0;
        end

        checks++;
        if (hif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b want 1", name, hif.req_ready);
        end
        hif.req_valid  = 1'b1;
        hif.req_op     = op_e'(op);
        hif.req_key    = key;
        hif.req_value  = val;
        hif.resp_ready = (delay == 0);
        step();
        hif.req_valid = 1'b0;
        hif.req_key   = KW'($urandom);
        hif.req_value = $urandom;

        n = 0;
        while (!hif.resp_valid && (n < TO + 3)) begin
            n++;
            checks++;
            if ({get_en, put_en, del_en} !== exp_en ||
                {get_enter, put_enter, del_enter} !== ((n == 1) ? exp_en : 3'b000) ||
                key_out !== key || value_out !== val) begin
                errors++;
                $display("FAIL %s op_cycle%0d: en=%b enter=%b key=%h val=%h want en=%b key=%h val=%h",
                         name, n, {get_en, put_en, del_en}, {get_enter, put_enter, del_enter},
                         key_out, value_out, exp_en, key, val);
            end
            get_cmd      = (op == 2'd1 && n == cmd_cycle) ? cmd : ((op == 2'd1) ? 2'b00 : 2'($urandom));
            put_cmd      = (op == 2'd2 && n == cmd_cycle) ? cmd : ((op == 2'd2) ? 2'b00 : 2'($urandom));
            del_cmd      = (op == 2'd3 && n == cmd_cycle) ? cmd : ((op == 2'd3) ? 2'b00 : 2'($urandom));
            get_value_in = (n == cmd_cycle) ? gv : $urandom;
            step();
        end
        get_cmd = 2'b00; put_cmd = 2'b00; del_cmd = 2'b00;

        checks++;
        if (hif.resp_valid !== 1'b1 || n != exp_cycles) begin
            errors++;
            $display("FAIL %s latency: resp_valid=%b after %0d op cycles, want 1 after %0d",
                     name, hif.resp_valid, n, exp_cycles);
        end
        checks++;
        if (hif.resp_status !== exp_status || hif.resp_value !== exp_value ||
            {get_en, put_en, del_en, get_enter, put_enter, del_enter} !== 6'b0 || hif.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s response: status=%0d value=%h en=%b ready=%b want status=%0d value=%h en=0 ready=0",
                     name, hif.resp_status, hif.resp_value, {get_en, put_en, del_en}, hif.req_ready,
                     exp_status, exp_value);
        end
        held_status = hif.resp_status;
        held_value  = hif.resp_value;
        for (int i = 0; i < delay; i++) begin
            step();
            checks++;
            if (hif.resp_valid !== 1'b1 || hif.resp_status !== exp_status ||
                hif.resp_value !== exp_value || hif.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b status=%0d value=%h ready=%b want valid=1 status=%0d value=%h ready=0 (first seen %0d/%h)",
                         name, i, hif.resp_valid, hif.resp_status, hif.resp_value, hif.req_ready,
                         exp_status, exp_value, held_status, held_value);
            end
        end
        hif.resp_ready = 1'b1;
        step();
        hif.resp_ready = 1'b0;
        checks++;
        if (hif.resp_valid !== 1'b0 || hif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: resp_valid=%b req_ready=%b want 0/1", name, hif.resp_valid, hif.req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (hif.req_ready !== 1'b1 || hif.resp_valid !== 1'b0 || hif.resp_status !== STATUS_OK ||
            hif.resp_value !== '0 || key_out !== '0 || value_out !== '0 ||
            {get_en, put_en, del_en, get_enter, put_enter, del_enter} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rv=%b st=%0d val=%h key=%h vo=%h en=%b want 1/0/0/0/0/0/0",
                     hif.req_ready, hif.resp_valid, hif.resp_status, hif.resp_value, key_out, value_out,
                     {get_en, put_en, del_en, get_enter, put_enter, del_enter});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_del();
        int seen;
        hif.req_valid = 1'b1; hif.req_op = OP_DEL; hif.req_key = 16'h0bad; hif.req_value = 32'h1;
        hif.resp_ready = 1'b1;
        step();
        hif.req_valid = 1'b0;
        repeat (2) step();
        checks++;
        if (del_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_del_active: del_en=%b want 1", del_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (del_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_del_drop: del_en=%b want 0", del_en);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < TO + 4; i++) begin
            step();
            if (hif.resp_valid !== 1'b0 || hif.req_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_del_after: %0d bad cycles (resp_valid or !req_ready), want 0", seen);
        end
        hif.resp_ready = 1'b0;
    endtask

    task automatic test_nop();
        run_op(2'd0, 16'h0001, 32'h1111_2222, 0, 2'b00, 32'h0, 0, "nop");
    endtask

    task automatic test_get_hit();
        run_op(2'd1, 16'h1234, 32'h0, 3, 2'b10, 32'hDEAD_BEEF, 0, "get_hit");
        run_op(2'd0, 16'h0002, 32'h0, 0, 2'b00, 32'h0, 1, "nop_after_get");
    endtask

    task automatic test_errors();
        run_op(2'd3, 16'h00aa, 32'h0, 2, 2'b01, 32'h0, 0, "del_miss");
        run_op(2'd2, 16'h00bb, 32'hcafe_f00d, 4, 2'b01, 32'h0, 0, "put_full");
        run_op(2'd1, 16'h00cc, 32'h0, 2, 2'b11, 32'h5555_aaaa, 0, "get_both");
        run_op(2'd2, 16'h00dd, 32'h7, 3, 2'b11, 32'h0, 0, "put_both");
    endtask

    task automatic test_timeout();
        run_op(2'd3, 16'h0100, 32'h0, 0, 2'b00, 32'h0, 0, "del_timeout");
        run_op(2'd3, 16'h0101, 32'h0, TO, 2'b10, 32'h0, 0, "del_done_last");
        run_op(2'd1, 16'h0102, 32'h0, 1, 2'b10, 32'h1234_5678, 0, "get_entry_ignored");
    endtask

    task automatic test_back_to_back();
        run_op(2'd2, 16'h0200, 32'h0bad_cafe, 2, 2'b10, 32'h0, 5, "bp_put");
        run_op(2'd1, 16'h0201, 32'h0, 5, 2'b10, 32'h8765_4321, 0, "b2b_get");
        run_op(2'd0, 16'h0202, 32'h0, 0, 2'b00, 32'h0, 0, "b2b_nop");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), KW'($urandom), $urandom, int'($urandom_range(1, TO + 2)),
                   2'($urandom), $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        hif.req_valid = 1'b0; hif.req_op = OP_NOP; hif.req_key = '0; hif.req_value = '0;
        hif.resp_ready = 1'b0;
        get_cmd = 2'b00; put_cmd = 2'b00; del_cmd = 2'b00; get_value_in = '0;
        test_reset();
        test_reset_mid_del();
        test_nop();
        test_get_hit();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
